// File: rtl/udm_uart_rx.sv
// UDM debug-link 8N1 serial receiver; `UDM_UART_RX_PARITY_EN adds an even-parity bit (8E1).
// Latency: rx_valid_o rises SYNC_STAGES + 2 + div/2 + 9*div cycles after the start edge (+div with parity).
// Backpressure: one-entry holding register; a byte that arrives while it is full and unread is dropped with overrun_o.
module udm_uart_rx #(
  parameter int DIV_WIDTH   = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 arst_n_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic                 rx_i,
  output logic [7:0]           rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 frame_err_o,
  output logic                 overrun_o,
`ifdef UDM_UART_RX_PARITY_EN
  output logic                 parity_err_o,
`endif
  output logic                 busy_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UDM_UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_e;

  localparam logic [DIV_WIDTH-1:0] ONE     = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] DIV_MIN = DIV_WIDTH'(4);

  state_e                   state_q, state_d;
  logic [SYNC_STAGES-1:0]   sync_q, sync_d;
  logic [DIV_WIDTH-1:0]     div_q, div_d;
  logic [DIV_WIDTH-1:0]     cnt_q, cnt_d;
  logic [2:0]               idx_q, idx_d;
  logic [7:0]               shift_q, shift_d;
  logic                     deliver_q, deliver_d;
  logic                     frame_err_q, frame_err_d;
  logic                     overrun_q, overrun_d;
  logic [7:0]               data_q, data_d;
  logic                     valid_q, valid_d;
`ifdef UDM_UART_RX_PARITY_EN
  logic                     par_err_q, par_err_d;
  logic                     par_bad_q, par_bad_d;
`endif

  logic rx_s;
  logic start_smp;
  logic bit_smp;

  assign rx_s      = sync_q[SYNC_STAGES-1];
  assign start_smp = (state_q == S_START) && (cnt_q == ((div_q >> 1) - ONE));
  assign bit_smp   = (cnt_q == (div_q - ONE));

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q     <= S_IDLE;
      sync_q      <= '1;
      div_q       <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      deliver_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
`ifdef UDM_UART_RX_PARITY_EN
      par_err_q   <= 1'b0;
      par_bad_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      deliver_q   <= deliver_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
`ifdef UDM_UART_RX_PARITY_EN
      par_err_q   <= par_err_d;
      par_bad_q   <= par_bad_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!rx_s) state_d = S_START;
      S_START: if (start_smp) state_d = rx_s ? S_IDLE : S_DATA;
`ifdef UDM_UART_RX_PARITY_EN
      S_DATA:   if (bit_smp && idx_q == 3'd7) state_d = S_PARITY;
      S_PARITY: if (bit_smp) state_d = S_STOP;
`else
      S_DATA:   if (bit_smp && idx_q == 3'd7) state_d = S_STOP;
`endif
      S_STOP:  if (bit_smp) state_d = rx_s ? S_IDLE : S_BREAK;
      // A held-low line after a bad stop bit must not look like a new start edge.
      S_BREAK: if (rx_s) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], rx_i};
    div_d       = div_q;
    cnt_d       = cnt_q + ONE;
    idx_d       = idx_q;
    shift_d     = shift_q;
    deliver_d   = 1'b0;
    frame_err_d = 1'b0;
`ifdef UDM_UART_RX_PARITY_EN
    par_err_d   = 1'b0;
    par_bad_d   = par_bad_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          div_d = (div_i < DIV_MIN) ? DIV_MIN : div_i;
`ifdef UDM_UART_RX_PARITY_EN
          par_bad_d = 1'b0;
`endif
        end
      end
      S_START: begin
        if (start_smp) begin
          cnt_d = '0;
          idx_d = '0;
        end
      end
      S_DATA: begin
        if (bit_smp) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          idx_d          = idx_q + 3'd1;
        end
      end
`ifdef UDM_UART_RX_PARITY_EN
      S_PARITY: begin
        if (bit_smp) begin
          cnt_d = '0;
          if (^{shift_q, rx_s}) begin
            par_err_d = 1'b1;
            par_bad_d = 1'b1;
          end
        end
      end
`endif
      S_STOP: begin
        if (bit_smp) begin
          cnt_d = '0;
          if (rx_s) begin
`ifdef UDM_UART_RX_PARITY_EN
            deliver_d = !par_bad_q;
`else
            deliver_d = 1'b1;
`endif
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: cnt_d = '0;
    endcase
  end

  // A same-cycle pop frees the holding register, so a delivery then is not an overrun.
  always_comb begin
    valid_d   = valid_q;
    data_d    = data_q;
    overrun_d = 1'b0;
    if (valid_q && rx_ready_i) valid_d = 1'b0;
    if (deliver_q) begin
      if (!valid_q || rx_ready_i) begin
        valid_d = 1'b1;
        data_d  = shift_q;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_comb begin
    busy_o       = (state_q != S_IDLE);
    rx_data_o    = data_q;
    rx_valid_o   = valid_q;
    frame_err_o  = frame_err_q;
    overrun_o    = overrun_q;
`ifdef UDM_UART_RX_PARITY_EN
    parity_err_o = par_err_q;
`endif
  end

endmodule

// File: tb/tb_udm_uart_rx.sv
// Directed bench for udm_uart_rx: serial driver + expected-byte queue, popped by a handshake monitor.
module tb_udm_uart_rx;

`ifdef UDM_UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic        clk_i = 1'b0;
  logic        arst_n_i;
  logic [31:0] div_i;
  logic        rx_i;
  logic [7:0]  rx_data_o;
  logic        rx_valid_o;
  logic        rx_ready_i;
  logic        frame_err_o;
  logic        overrun_o;
  logic        parity_err_o;
  logic        busy_o;

  int n_cmp = 0;
  int n_mis = 0;
  int n_ferr = 0;
  int n_ovr = 0;
  int n_perr = 0;
  logic [7:0] exp_q[$];

  always #5 clk_i = ~clk_i;

  udm_uart_rx #(.DIV_WIDTH(32), .SYNC_STAGES(2)) dut (
    .clk_i       (clk_i),
    .arst_n_i    (arst_n_i),
    .div_i       (div_i),
    .rx_i        (rx_i),
    .rx_data_o   (rx_data_o),
    .rx_valid_o  (rx_valid_o),
    .rx_ready_i  (rx_ready_i),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o),
`ifdef UDM_UART_RX_PARITY_EN
    .parity_err_o(parity_err_o),
`endif
    .busy_o      (busy_o)
  );

`ifndef UDM_UART_RX_PARITY_EN
  assign parity_err_o = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // One frame; par_flip inverts the even-parity bit when parity is built in.
  task automatic send(input logic [7:0] b, input int bd, input logic stop, input logic par_flip);
    rx_i = 1'b0;
    tick(bd);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      tick(bd);
    end
    if (PB == 1) begin
      rx_i = (^b) ^ par_flip;
      tick(bd);
    end
    rx_i = stop;
    tick(bd);
  endtask

  always @(negedge clk_i) begin
    if (arst_n_i) begin
      if (frame_err_o) n_ferr++;
      if (overrun_o) n_ovr++;
      if (parity_err_o) n_perr++;
      if (rx_valid_o && rx_ready_i) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_mis++;
          $display("FAIL unexpected_byte: got 0x%0h, expected no byte", rx_data_o);
        end else begin
          check("rx_byte", 32'(rx_data_o), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    arst_n_i   = 1'b0;
    rx_i       = 1'b1;
    rx_ready_i = 1'b1;
    div_i      = 32'd16;
    tick(3);
    check("rst_valid", 32'(rx_valid_o), 32'd0);
    check("rst_data", 32'(rx_data_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_ferr", 32'(frame_err_o), 32'd0);
    check("rst_ovr", 32'(overrun_o), 32'd0);
    arst_n_i = 1'b1;
    tick(3);

    // Slow baud: exact first-valid latency; a mid-frame divider change must be ignored.
    div_i = 32'd868;
    exp_q.push_back(8'h55);
    fork
      send(8'h55, 868, 1'b1, 1'b0);
      begin
        lat = 0;
        while (!rx_valid_o && lat < 20000) begin
          tick(1);
          lat++;
          if (lat == 100) div_i = 32'd20;
        end
        check("t1_latency", 32'(lat), 32'(4 + 434 + (9 + PB) * 868));
        tick(1);
        check("t1_valid_drop", 32'(rx_valid_o), 32'd0);
      end
    join
    tick(5);

    // Short start glitch.
    div_i = 32'd16;
    rx_i  = 1'b0;
    tick(5);
    check("t2_busy_mid", 32'(busy_o), 32'd1);
    rx_i = 1'b1;
    tick(6);
    check("t2_busy_idle", 32'(busy_o), 32'd0);
    tick(20);
    check("t2_no_ferr", 32'(n_ferr), 32'd0);

    // Bad stop bit, line held low, then a clean frame.
    send(8'hA3, 16, 1'b0, 1'b0);
    tick(40);
    check("t3_busy_break", 32'(busy_o), 32'd1);
    rx_i = 1'b1;
    tick(20);
    check("t3_ferr_count", 32'(n_ferr), 32'd1);
    check("t3_busy_idle", 32'(busy_o), 32'd0);
    exp_q.push_back(8'h3C);
    send(8'h3C, 16, 1'b1, 1'b0);
    tick(10);

    // Overrun with a full holding register, then delivery coinciding with a pop.
    rx_ready_i = 1'b0;
    exp_q.push_back(8'h12);
    send(8'h12, 16, 1'b1, 1'b0);
    send(8'h34, 16, 1'b1, 1'b0);
    tick(8);
    check("t4_held_data", 32'(rx_data_o), 32'h12);
    check("t4_held_valid", 32'(rx_valid_o), 32'd1);
    check("t4_ovr_count", 32'(n_ovr), 32'd1);
    exp_q.push_back(8'h34);
    fork
      send(8'h34, 16, 1'b1, 1'b0);
      begin
        tick(155 + PB * 16);
        rx_ready_i = 1'b1;
        tick(1);
        rx_ready_i = 1'b0;
        check("t4_swap_data", 32'(rx_data_o), 32'h34);
        check("t4_swap_valid", 32'(rx_valid_o), 32'd1);
      end
    join
    check("t4_ovr_unchanged", 32'(n_ovr), 32'd1);
    rx_ready_i = 1'b1;
    tick(3);
    check("t4_drained", 32'(rx_valid_o), 32'd0);

    // Zero-gap frames, then reset in the middle of a fourth.
    exp_q.push_back(8'h55);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send(8'h55, 16, 1'b1, 1'b0);
    send(8'h00, 16, 1'b1, 1'b0);
    send(8'hFF, 16, 1'b1, 1'b0);
    tick(5);
    check("t5_last_data", 32'(rx_data_o), 32'hFF);
    rx_i = 1'b0;
    tick(52);
    check("t5_busy_data", 32'(busy_o), 32'd1);
    arst_n_i = 1'b0;
    #1;
    check("t5_rst_valid", 32'(rx_valid_o), 32'd0);
    check("t5_rst_data", 32'(rx_data_o), 32'd0);
    check("t5_rst_busy", 32'(busy_o), 32'd0);
    rx_i = 1'b1;
    tick(3);
    arst_n_i = 1'b1;
    tick(200);
    check("t5_post_valid", 32'(rx_valid_o), 32'd0);
    check("t5_post_busy", 32'(busy_o), 32'd0);

    // Divider below the minimum is clamped to 4 clocks per bit.
    div_i = 32'd2;
    exp_q.push_back(8'hA5);
    send(8'hA5, 4, 1'b1, 1'b0);
    tick(10);

`ifdef UDM_UART_RX_PARITY_EN
    div_i = 32'd16;
    exp_q.push_back(8'h07);
    send(8'h07, 16, 1'b1, 1'b0);
    send(8'h07, 16, 1'b1, 1'b1);
    tick(10);
    check("t6_perr_count", 32'(n_perr), 32'd1);
`endif

    tick(10);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("ferr_total", 32'(n_ferr), 32'd1);
    check("ovr_total", 32'(n_ovr), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
